// File: rtl/jk_check_pkg.sv
// rtl/jk_check_pkg.sv - shared types and constants for the JK response checker
//
// Purpose : FSM state encoding and JK opcode constants used by the checker
//           top level and the golden model.
// Ports   : none (package).
package jk_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // {J,K} opcodes of the JK flip-flop
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_golden_model.sv
// rtl/jk_golden_model.sv - golden JK flip-flop model with a known/unknown flag
//
// Purpose : Tracks the expected Q of the JK flip-flop under test. The known
//           flag stays low until the stimulus forces Q to a defined value,
//           because hold/toggle of an undefined Q is still undefined.
// Ports   : CLK        clock, rising edge
//           rst_in     synchronous active-high reset (q and known to 0)
//           clr_in     start-of-run clear (q and known to 0)
//           en_in      apply one stimulus vector this edge
//           J_in/K_in  JK stimulus bits
//           vrst_in    stimulus reset bit (forces q to 0)
//           q_out      model Q
//           known_out  model Q is defined
module jk_golden_model
  import jk_check_pkg::*;
(
  input  logic CLK,
  input  logic rst_in,
  input  logic clr_in,
  input  logic en_in,
  input  logic J_in,
  input  logic K_in,
  input  logic vrst_in,
  output logic q_out,
  output logic known_out
);

  logic q_q, q_d;
  logic known_q, known_d;

  always_comb begin
    q_d     = q_q;
    known_d = known_q;
    if (clr_in) begin
      q_d     = 1'b0;
      known_d = 1'b0;
    end else if (en_in) begin
      if (vrst_in) begin
        q_d     = 1'b0;
        known_d = 1'b1;
      end else begin
        case ({J_in, K_in})
          JK_RST: begin
            q_d     = 1'b0;
            known_d = 1'b1;
          end
          JK_SET: begin
            q_d     = 1'b1;
            known_d = 1'b1;
          end
          JK_TOG: q_d = ~q_q;  // known flag carried through unchanged
          default: ;           // JK_HOLD
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst_in) begin
      q_q     <= 1'b0;
      known_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      known_q <= known_d;
    end
  end

  assign q_out     = q_q;
  assign known_out = known_q;

endmodule

// File: rtl/jk_response_checker.sv
// rtl/jk_response_checker.sv - self-test response checker for a JK flip-flop
//
// Purpose : Accepts the {J,K,rst} stimulus stream, updates a golden model,
//           compares the DUT Q one cycle after each accepted vector and
//           reports error count, first failing index and a pass verdict.
// Ports   : CLK                 clock, rising edge
//           rst_in              synchronous active-high reset
//           start_in            one-cycle pulse starting a run (IDLE/DONE)
//           valid_in            stimulus vector present this cycle
//           J_in/K_in/vrst_in   stimulus vector
//           Q_dut_in            Q of the flip-flop under test
//           busy_out            run in progress
//           done_out            run complete
//           pass_out            verdict, valid while done_out is high
//           err_cnt_out         mismatch count, saturating
//           vec_cnt_out         vectors accepted this run
//           fail_seen_out       at least one mismatch this run
//           first_fail_idx_out  0-based index of the first mismatch
//           q_model_out         golden model Q
module jk_response_checker
  import jk_check_pkg::*;
#(
  parameter int NUM_VECTORS = 5,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             valid_in,
  input  logic             J_in,
  input  logic             K_in,
  input  logic             vrst_in,
  input  logic             Q_dut_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [CNT_W-1:0] err_cnt_out,
  output logic [CNT_W-1:0] vec_cnt_out,
  output logic             fail_seen_out,
  output logic [CNT_W-1:0] first_fail_idx_out,
  output logic             q_model_out
);

  localparam logic [CNT_W-1:0] NUM_V   = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_fail_q, first_fail_d;
  logic [CNT_W-1:0] pend_idx_q, pend_idx_d;
  logic             fail_seen_q, fail_seen_d;
  logic             pend_q, pend_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             model_clr;
  logic             accept;
  logic             q_model;
  logic             model_known;

  jk_golden_model u_model (
    .CLK       (CLK),
    .rst_in    (rst_in),
    .clr_in    (model_clr),
    .en_in     (accept),
    .J_in      (J_in),
    .K_in      (K_in),
    .vrst_in   (vrst_in),
    .q_out     (q_model),
    .known_out (model_known)
  );

  always_comb begin
    state_d      = state_q;
    vec_cnt_d    = vec_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    pend_idx_d   = pend_idx_q;
    fail_seen_d  = fail_seen_q;
    pend_d       = pend_q;
    pass_d       = pass_q;
    model_clr    = 1'b0;
    accept       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d      = RUN;
          vec_cnt_d    = '0;
          err_cnt_d    = '0;
          first_fail_d = '0;
          pend_idx_d   = '0;
          fail_seen_d  = 1'b0;
          pend_d       = 1'b0;
          model_clr    = 1'b1;
        end
      end
      RUN: begin
        accept = valid_in && (vec_cnt_q != NUM_V);
        pend_d = accept;
        if (accept) begin
          vec_cnt_d  = vec_cnt_q + 1'b1;
          pend_idx_d = vec_cnt_q;
        end
        // Compare the previous vector against the pre-edge model value,
        // concurrently with the model absorbing the new vector.
        if (pend_q && model_known && (Q_dut_in != q_model)) begin
          if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (!fail_seen_q) begin
            fail_seen_d  = 1'b1;
            first_fail_d = pend_idx_q;
          end
        end
        // pend_q low means the last vector's compare has already happened
        if ((vec_cnt_q == NUM_V) && !pend_q) begin
          state_d = DONE;
          pass_d  = (err_cnt_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (rst_in) begin
      state_q      <= IDLE;
      vec_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      pend_idx_q   <= '0;
      fail_seen_q  <= 1'b0;
      pend_q       <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_cnt_q    <= vec_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      pend_idx_q   <= pend_idx_d;
      fail_seen_q  <= fail_seen_d;
      pend_q       <= pend_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy_out           = busy_q;
  assign done_out           = done_q;
  assign pass_out           = pass_q;
  assign err_cnt_out        = err_cnt_q;
  assign vec_cnt_out        = vec_cnt_q;
  assign fail_seen_out      = fail_seen_q;
  assign first_fail_idx_out = first_fail_q;
  assign q_model_out        = q_model;

endmodule

// File: tb/tb_jk_response_checker.sv
// tb/tb_jk_response_checker.sv - directed self-checking bench for jk_response_checker
module tb_jk_response_checker;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_s = 1'b0;
  logic       valid = 1'b0;
  logic       J = 1'b0;
  logic       K = 1'b0;
  logic       vrst = 1'b0;
  logic       q_dut = 1'b0;
  logic       q_dut_s = 1'b0;

  logic       busy, done, pass, fail_seen, q_model;
  logic [7:0] err_cnt, vec_cnt, first_fail;
  logic       busy_s, done_s, pass_s, fail_seen_s, q_model_s;
  logic [1:0] err_cnt_s, vec_cnt_s, first_fail_s;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  jk_response_checker dut (
    .CLK(CLK), .rst_in(rst), .start_in(start), .valid_in(valid),
    .J_in(J), .K_in(K), .vrst_in(vrst), .Q_dut_in(q_dut),
    .busy_out(busy), .done_out(done), .pass_out(pass),
    .err_cnt_out(err_cnt), .vec_cnt_out(vec_cnt), .fail_seen_out(fail_seen),
    .first_fail_idx_out(first_fail), .q_model_out(q_model)
  );

  jk_response_checker #(.NUM_VECTORS(3), .CNT_W(2)) dut_sat (
    .CLK(CLK), .rst_in(rst), .start_in(start_s), .valid_in(valid),
    .J_in(J), .K_in(K), .vrst_in(vrst), .Q_dut_in(q_dut_s),
    .busy_out(busy_s), .done_out(done_s), .pass_out(pass_s),
    .err_cnt_out(err_cnt_s), .vec_cnt_out(vec_cnt_s), .fail_seen_out(fail_seen_s),
    .first_fail_idx_out(first_fail_s), .q_model_out(q_model_s)
  );

  // vectors packed {v4,v3,v2,v1,v0}, each {J,K,rst}; q values packed {q4..q0}
  localparam logic [14:0] VEC_NORMAL  = {3'b000, 3'b010, 3'b110, 3'b100, 3'b001};
  localparam logic [4:0]  Q_NORMAL    = 5'b00010;
  localparam logic [4:0]  Q_FAULT2    = 5'b00110;
  localparam logic [14:0] VEC_UNKNOWN = {3'b110, 3'b100, 3'b001, 3'b110, 3'b000};
  localparam logic [4:0]  Q_UNKNOWN   = 5'b01011;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Vector k is driven in cycle k; the DUT Q for vector k-1 is driven in the
  // same cycle, since it is compared at the edge after acceptance.
  task automatic drive_run(input logic [14:0] vecs, input logic [4:0] qs, input int start_at);
    for (int k = 0; k <= 5; k++) begin
      start = (k == start_at);
      if (k < 5) begin
        valid = 1'b1;
        {J, K, vrst} = vecs[3*k +: 3];
      end else begin
        valid = 1'b0;
        {J, K, vrst} = 3'b000;
      end
      if (k > 0) q_dut = qs[k-1];
      tick();
    end
    start = 1'b0;
    q_dut = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, pass, fail_seen, q_model, err_cnt, vec_cnt, first_fail} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {busy, done, pass, fail_seen, q_model, err_cnt, vec_cnt, first_fail});
    end
    // valid in IDLE must be ignored
    valid = 1'b1;
    {J, K, vrst} = 3'b100;
    tick();
    tick();
    valid = 1'b0;
    {J, K, vrst} = 3'b000;
    checks++;
    if ({busy, vec_cnt, q_model} !== 10'd0) begin
      errors++;
      $display("FAIL idle_valid_ignored: busy=%0b vec=%0d q=%0b expected 0 0 0", busy, vec_cnt, q_model);
    end
  endtask

  task automatic test_normal_run();
    int cyc;
    do_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL normal_busy: got %0b expected 1", busy);
    end
    drive_run(VEC_NORMAL, Q_NORMAL, -1);
    wait_done(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL normal_latency: got %0d cycles expected 1 after last compare", cyc);
    end
    checks++;
    if ({pass, err_cnt, vec_cnt, fail_seen, busy} !== {1'b1, 8'd0, 8'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL normal_result: pass=%0b err=%0d vec=%0d fail=%0b busy=%0b expected 1 0 5 0 0",
               pass, err_cnt, vec_cnt, fail_seen, busy);
    end
  endtask

  task automatic test_single_fault();
    int cyc;
    do_start();
    checks++;
    if ({vec_cnt, err_cnt, done} !== 17'd0) begin
      errors++;
      $display("FAIL restart_clear: vec=%0d err=%0d done=%0b expected 0 0 0", vec_cnt, err_cnt, done);
    end
    drive_run(VEC_NORMAL, Q_FAULT2, -1);
    wait_done(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL fault_done: got %0d cycles expected 1", cyc);
    end
    checks++;
    if ({err_cnt, fail_seen, first_fail, pass} !== {8'd1, 1'b1, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL fault_result: err=%0d fail=%0b idx=%0d pass=%0b expected 1 1 2 0",
               err_cnt, fail_seen, first_fail, pass);
    end
  endtask

  task automatic test_unknown_start();
    int cyc;
    do_start();
    drive_run(VEC_UNKNOWN, Q_UNKNOWN, -1);
    wait_done(cyc);
    checks++;
    if ({cyc == 1, pass, err_cnt, fail_seen, vec_cnt} !== {1'b1, 1'b1, 8'd0, 1'b0, 8'd5}) begin
      errors++;
      $display("FAIL unknown_result: cyc=%0d pass=%0b err=%0d fail=%0b vec=%0d expected 1 1 0 0 5",
               cyc, pass, err_cnt, fail_seen, vec_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    do_start();
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1;
      {J, K, vrst} = VEC_NORMAL[3*k +: 3];
      if (k > 0) q_dut = Q_NORMAL[k-1];
      tick();
    end
    valid = 1'b0;
    {J, K, vrst} = 3'b000;
    checks++;
    if ({busy, vec_cnt} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL midrun_before_reset: busy=%0b vec=%0d expected 1 3", busy, vec_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_dut = 1'b0;
    checks++;
    if ({busy, done, pass, fail_seen, q_model, err_cnt, vec_cnt, first_fail} !== 29'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %b expected all zero",
               {busy, done, pass, fail_seen, q_model, err_cnt, vec_cnt, first_fail});
    end
    // still in IDLE: no start means no run
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: busy=%0b expected 0", busy);
    end
    do_start();
    drive_run(VEC_NORMAL, Q_NORMAL, -1);
    wait_done(cyc);
    checks++;
    if ({cyc == 1, pass, err_cnt, vec_cnt} !== {1'b1, 1'b1, 8'd0, 8'd5}) begin
      errors++;
      $display("FAIL midrun_rerun: cyc=%0d pass=%0b err=%0d vec=%0d expected 1 1 0 5",
               cyc, pass, err_cnt, vec_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    // valid in DONE must not touch counters or model (100 would set q to 1)
    valid = 1'b1;
    {J, K, vrst} = 3'b100;
    tick();
    tick();
    valid = 1'b0;
    {J, K, vrst} = 3'b000;
    checks++;
    if ({done, vec_cnt, q_model} !== {1'b1, 8'd5, 1'b0}) begin
      errors++;
      $display("FAIL done_valid_ignored: done=%0b vec=%0d q=%0b expected 1 5 0", done, vec_cnt, q_model);
    end
    do_start();
    checks++;
    if ({busy, done, vec_cnt, err_cnt} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL b2b_restart: busy=%0b done=%0b vec=%0d err=%0d expected 1 0 0 0",
               busy, done, vec_cnt, err_cnt);
    end
    // start pulse during RUN (cycle 2) must be ignored
    drive_run(VEC_NORMAL, Q_NORMAL, 2);
    wait_done(cyc);
    checks++;
    if ({cyc == 1, pass, err_cnt, vec_cnt} !== {1'b1, 1'b1, 8'd0, 8'd5}) begin
      errors++;
      $display("FAIL b2b_second_run: cyc=%0d pass=%0b err=%0d vec=%0d expected 1 1 0 5",
               cyc, pass, err_cnt, vec_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [11:0] vecs;
    logic [2:0]  qs;
    int          cyc;
    // vectors 001,100,100,(extra 010): model 0,1,1; DUT Q always opposite
    vecs = {3'b010, 3'b100, 3'b100, 3'b001};
    qs   = 3'b001;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      {J, K, vrst} = vecs[3*k +: 3];
      if (k > 0) q_dut_s = qs[k-1];
      tick();
    end
    valid = 1'b0;
    {J, K, vrst} = 3'b000;
    q_dut_s = 1'b0;
    cyc = 99;
    for (int i = 1; i <= 8; i++) begin
      if (done_s === 1'b1) begin
        cyc = i;
        break;
      end
      tick();
    end
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL sat_done: got %0d expected done on 2nd sample", cyc);
    end
    checks++;
    if ({err_cnt_s, vec_cnt_s, fail_seen_s, first_fail_s, pass_s} !== {2'd3, 2'd3, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL sat_result: err=%0d vec=%0d fail=%0b idx=%0d pass=%0b expected 3 3 1 0 0",
               err_cnt_s, vec_cnt_s, fail_seen_s, first_fail_s, pass_s);
    end
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_single_fault();
    test_unknown_start();
    test_reset_mid_run();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_response_checker.md
Name: jk_response_checker

Overview:
- Synthesizable response checker for the JK flip-flop test flow; it is the receiving end of the stimulus stream {J, K, rst} applied to the JK_ff under test.
- Holds a golden JK model updated from the same stimulus, compares it with the DUT Q one cycle later, and counts the vectors checked.
- Reports mismatch count, the index of the first failure, and a final pass/done verdict.
- Sits beside the DUT in on-board self-test and simulation benches.

Parameters:
- NUM_VECTORS, 5, number of stimulus vectors per run.
- CNT_W, 8, width of the vector, error and index counters. Must hold NUM_VECTORS.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  begins a run (one-cycle pulse).
- valid_in  input  1  J_in/K_in/vrst_in were sampled by the DUT at the closing edge of this cycle.
- J_in  input  1  J stimulus bit.
- K_in  input  1  K stimulus bit.
- vrst_in  input  1  reset bit of the stimulus vector; this is the DUT's own reset.
- Q_dut_in  input  1  DUT Q output.
- busy_out  output  1  high while in RUN.
- done_out  output  1  high in DONE.
- pass_out  output  1  valid when done_out is high; 1 means err_cnt_out == 0.
- err_cnt_out  output  CNT_W  number of mismatches; saturates at all ones.
- vec_cnt_out  output  CNT_W  number of vectors accepted this run.
- fail_seen_out  output  1  set by the first mismatch of the run.
- first_fail_idx_out  output  CNT_W  vector index (0-based) of the first mismatch.
- q_model_out  output  1  golden model Q.

Behaviour:
- Clock and reset: single clock CLK; rst_in is synchronous and active-high. When rst_in=1 at an edge, every output and internal register goes to 0, and the state goes to IDLE with model_known=0. This also applies in the middle of a run.
- States:
  - IDLE: start_in=1 moves to RUN and clears err_cnt, vec_cnt, fail_seen, first_fail_idx, pend and model_known. valid_in is ignored.
  - RUN: busy_out=1. start_in is ignored.
  - DONE: done_out=1 and the counters are held. start_in=1 moves to RUN with the same clears as from IDLE. valid_in is ignored.
- Golden model update, in RUN with valid_in=1, at the edge:
  - vrst_in=1: q_model becomes 0 and known becomes 1.
  - Otherwise {J,K}=00: hold.
  - 01: q_model becomes 0 and known becomes 1.
  - 10: q_model becomes 1 and known becomes 1.
  - 11: q_model is inverted; known is unchanged.
  - Hold and toggle on an unknown model leave it unknown.
- Acceptance: at the same edge, vec_cnt increments, pend becomes 1 and pend_idx becomes the old vec_cnt.
  - With valid_in=0, pend becomes 0.
  - Extra valid_in after NUM_VECTORS vectors have been accepted is ignored.
- Compare, one cycle after acceptance: at the edge where pend=1, if known=1 and Q_dut_in != q_model:
  - err_cnt increments, saturating.
  - If fail_seen=0: fail_seen becomes 1 and first_fail_idx becomes pend_idx.
  - If known=0, no compare is made and no error is counted.
- Simultaneous events: a new vector's model update and the previous vector's compare occur at the same edge. The compare uses the pre-edge q_model, which is the value after the previous update.
- Completion: when vec_cnt == NUM_VECTORS and pend=0 (the last compare has been performed), RUN moves to DONE at the next edge. pass_out becomes (err_cnt == 0) at that same edge.
- Latency: done_out rises 2 cycles after the edge that accepts the last vector.

Decomposition:
- Package jk_check_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - JK opcode constants: JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
- Sub-module jk_golden_model: inputs CLK, rst_in, clr_in, en_in, J_in, K_in, vrst_in; outputs q_out and known_out. It implements only the model-update rules above.
- The top level owns the FSM, the pend pipeline, the counters and first-fail capture.

Test Plan:
- Normal run: reset, start, vectors {J,K,rst} = 001, 100, 110, 010, 000 with Q_dut_in tracking 0,1,0,0,0 one cycle later -> done_out=1, pass_out=1, err_cnt_out=0, vec_cnt_out=5.
- Single fault: same vectors but force Q_dut_in=1 in the compare cycle of vector 2 -> err_cnt_out=1, fail_seen_out=1, first_fail_idx_out=2, pass_out=0.
- Unknown start: first vectors 000 and 110 with Q_dut_in=1, then 001 and onward correct -> no errors counted for indices 0 and 1; pass_out=1.
- Reset mid-run: assert rst_in after 3 vectors -> next cycle all outputs are 0 and the state is IDLE; a subsequent start gives a full clean 5-vector pass.
- Back-to-back runs and ignored inputs: start_in during RUN and valid_in in IDLE/DONE change nothing; start_in in DONE clears counters and a second run completes with vec_cnt_out=5.
- Saturation: CNT_W=2, NUM_VECTORS=3, three injected faults with a known model -> err_cnt_out=3 and it does not wrap.
